apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
Single-outstanding APB master that turns a simple request/response handshake into APB SETUP/ACCESS transfers. It sits directly upstream of APB slaves, such as the APB slave RAM model, and drives PSEL, PENABLE, PWRITE, PADDR and PWDATA. It returns read data and error status to the requester. A built-in wait-state timeout guarantees completion even if a slave never asserts PREADY.

Parameters:
AWIDTH, 8, APB address width.
DWIDTH, 8, APB data width.
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced termination; 0 disables the timeout.

Ports:
PCLK  in  1  clock; all logic is on the rising edge.
PRESETN  in  1  reset, asynchronous, active-low.
REQ_VALID  in  1  request present.
REQ_READY  out  1  controller idle; can accept a request.
REQ_WRITE  in  1  1 = write, 0 = read.
REQ_ADDR  in  AWIDTH  transfer address.
REQ_WDATA  in  DWIDTH  write data.
RSP_VALID  out  1  one-cycle completion pulse.
RSP_RDATA  out  DWIDTH  read data; 0 for writes and for errors.
RSP_ERR  out  1  PSLVERR seen or timeout; valid with RSP_VALID.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  AWIDTH  APB address.
PWDATA  out  DWIDTH  APB write data.
PRDATA  in  DWIDTH  APB read data.
PREADY  in  1  APB ready; tie to 1 for no-wait slaves.
PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, PCLK. PRESETN is asynchronous, active-low; assertion immediately forces state to IDLE.
- Reset values: PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR = 0; PADDR, PWDATA, RSP_RDATA = 0; wait counter = 0.
- All outputs except REQ_READY are registered. REQ_READY = (state == IDLE), decoded from the state register.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - REQ_READY = 1; PSEL = 0; PENABLE = 0.
  - Acceptance occurs at an edge where REQ_VALID = 1 and REQ_READY = 1.
  - On acceptance: latch REQ_WRITE into PWRITE, REQ_ADDR into PADDR, REQ_WDATA into PWDATA; go to SETUP.
- SETUP:
  - PSEL = 1; PENABLE = 0; REQ_READY = 0.
  - Unconditionally go to ACCESS on the next edge.
- ACCESS:
  - PSEL = 1; PENABLE = 1.
  - At an edge with PREADY = 1: complete the transfer and go to IDLE.
  - At an edge with PREADY = 0: increment the wait counter.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT at an edge with PREADY still low: complete the transfer with error and go to IDLE.
- Completion:
  - RSP_VALID = 1 for exactly one cycle, the first IDLE cycle.
  - RSP_RDATA = PRDATA when the transfer is a read, PREADY = 1 and PSLVERR = 0; otherwise RSP_RDATA = 0.
  - RSP_ERR = PSLVERR (sampled with PREADY) OR timeout.
  - The wait counter clears to 0.
- Hold rules:
  - PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS.
  - After completion they hold their values until the next acceptance; they do not return to 0.
- Latency:
  - Accept at edge N. SETUP is cycle N+1, ACCESS is cycle N+2.
  - With PREADY = 1, RSP_VALID is high in cycle N+3, where REQ_READY is also 1 again.
  - Minimum period is 3 cycles per transfer; each wait state adds 1.
- Back-to-back transfers:
  - A request accepted in the RSP_VALID cycle is legal.
  - PSEL is guaranteed low for at least one cycle between transfers.
  - PSEL is never high for more than 2 consecutive cycles when PREADY = 1.
- PENABLE is never high without PSEL, and never high in the cycle after SETUP is skipped.
- REQ_VALID while busy is ignored; the requester must hold the request until REQ_READY.
- Reset mid-transfer: the APB outputs drop immediately, no RSP_VALID is produced for the aborted transfer, and the request is lost.
- Wait counter width is clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.

Test Plan:
- Write then read, against the APB slave RAM model with PREADY = 1: write addr 0x12 data 0xA5, then read 0x12 -> PSEL/PENABLE 2-cycle pattern, no protocol-checker messages, RSP_RDATA = 0xA5, RSP_ERR = 0, RSP_VALID 3 cycles after each accept.
- Back-to-back: REQ_VALID held high for 4 writes to 0x00..0x03 (data 0x10..0x13), then 4 reads -> one request accepted every 3 cycles, PSEL low 1 cycle between transfers, reads return 0x10..0x13 in order.
- Wait states: slave holds PREADY low for 3 ACCESS cycles, then returns PRDATA = 0x3C -> PENABLE high for 4 cycles, PADDR stable throughout, RSP_VALID 6 cycles after accept, RSP_RDATA = 0x3C.
- Timeout: TIMEOUT = 4, PREADY stuck at 0 -> ACCESS lasts exactly 4 cycles, RSP_ERR = 1, RSP_RDATA = 0, next request accepted normally.
- Slave error: PSLVERR = 1 with PREADY = 1 on a read of 0x7F -> RSP_ERR = 1, RSP_RDATA = 0; a following clean read gives RSP_ERR = 0.
- Reset mid-ACCESS: PRESETN pulsed low for 2 ns while PENABLE = 1 and PREADY = 0 -> PSEL, PENABLE and RSP_VALID go 0 asynchronously, no response pulse, REQ_READY = 1 afterwards, next transfer is correct.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB master with request/response handshake
// and a wait-state timeout so that every accepted transfer completes.
module apb_master_ctrl #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [AWIDTH-1:0] REQ_ADDR,
    input  logic [DWIDTH-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DWIDTH-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [AWIDTH-1:0]   paddr_q;
    logic [DWIDTH-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic [DWIDTH-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [CW-1:0]       wait_q;
    logic [CW-1:0]       wait_d;
    logic                timeout_hit;

    // Saturating increment: the counter must never wrap back to zero.
    assign wait_d      = (&wait_q) ? wait_q : wait_q + 1'b1;
    assign timeout_hit = (TIMEOUT > 0) && (wait_d == CW'(TIMEOUT));

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        pwrite_q <= REQ_WRITE;
                        paddr_q  <= REQ_ADDR;
                        pwdata_q <= REQ_WDATA;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                        rsp_err_q   <= PSLVERR;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        wait_q      <= '0;
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        wait_q      <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed bench for apb_master_ctrl with a small APB RAM slave
// whose PREADY delay and PSLVERR are set per step.
module tb_apb_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [7:0] mem [256];
    int         acc_cnt;
    int         wait_n;
    logic       slv_err;

    apb_master_ctrl #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(4)) dut (
        .PCLK(clk), .PRESETN(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata),
        .PREADY(pready), .PSLVERR(pslverr)
    );

    always #5 clk = ~clk;

    // RAM slave: PREADY rises after wait_n ACCESS cycles.
    assign pready  = (acc_cnt >= wait_n);
    assign prdata  = mem[paddr];
    assign pslverr = slv_err & psel & penable & pready;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
        if (psel && penable && pwrite && pready && !slv_err) mem[paddr] <= pwdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                        input logic [7:0] data, input int exp_lat,
                        input logic [7:0] exp_rdata, input logic exp_err);
        int lat;
        int en_cycles;
        lat = 0;
        while (!req_ready && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_ready"}, req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
        step();
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        lat = 1;
        en_cycles = 0;
        while (!rsp_valid && lat < 20) begin
            if (lat == 1) begin
                chk({tag, "_setup"}, {req_ready, psel, penable, pwrite}, {1'b0, 1'b1, 1'b0, wr});
                chk({tag, "_setup_addr"}, paddr, addr);
                if (wr) chk({tag, "_setup_wdata"}, pwdata, data);
            end else begin
                chk({tag, "_access_hold"}, {psel, paddr}, {1'b1, addr});
                if (penable) en_cycles++;
            end
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_penable_cycles"}, en_cycles, exp_lat - 2);
        chk({tag, "_rsp"}, {rsp_err, rsp_rdata}, {exp_err, exp_rdata});
        chk({tag, "_idle"}, {req_ready, psel, penable}, 3'b100);
        step();
        chk({tag, "_pulse"}, rsp_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_d;
        int         last_acc;
        int         lat;
        int         saw_rsp;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h40] = 8'h3C;
        mem[8'h20] = 8'h77;
        mem[8'h7F] = 8'h55;
        wait_n = 0; slv_err = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rst_n = 1'b0;
        step(); step();
        chk("reset_ctrl", {req_ready, psel, penable, pwrite, rsp_valid, rsp_err}, 6'b100000);
        chk("reset_data", {paddr, pwdata, rsp_rdata}, 24'h0);
        rst_n = 1'b1;
        step();

        xfer("wr12", 1'b1, 8'h12, 8'hA5, 3, 8'h00, 1'b0);
        xfer("rd12", 1'b0, 8'h12, 8'h00, 3, 8'hA5, 1'b0);
        chk("hold_after_rsp", {pwrite, paddr}, {1'b0, 8'h12});

        // Back-to-back: four writes then four reads with REQ_VALID held high.
        last_acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = (i < 4);
            req_addr  = 8'(i % 4);
            req_wdata = 8'h10 + 8'(i % 4);
            lat = 0;
            while (!req_ready && lat < 20) begin
                step();
                lat++;
            end
            if (i > 0) begin
                chk("b2b_gap", cycle - last_acc, 3);
                chk("b2b_rsp_psel", {rsp_valid, psel}, 2'b10);
                exp_d = (i >= 5) ? 8'h10 + 8'(i - 5) : 8'h00;
                chk("b2b_rdata", rsp_rdata, exp_d);
            end
            last_acc = cycle;
            step();
        end
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("b2b_last_rdata", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h13});
        step();

        wait_n = 3;
        xfer("wait3", 1'b0, 8'h40, 8'h00, 6, 8'h3C, 1'b0);

        wait_n = 255;
        xfer("timeout", 1'b0, 8'h20, 8'h00, 6, 8'h00, 1'b1);
        wait_n = 0;
        xfer("post_to", 1'b0, 8'h20, 8'h00, 3, 8'h77, 1'b0);

        slv_err = 1'b1;
        xfer("slverr", 1'b0, 8'h7F, 8'h00, 3, 8'h00, 1'b1);
        slv_err = 1'b0;
        xfer("post_err", 1'b0, 8'h7F, 8'h00, 3, 8'h55, 1'b0);

        // Reset while stalled in ACCESS.
        wait_n = 255;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 8'hEE;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_pre", {psel, penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {psel, penable, rsp_valid, req_ready}, 4'b0001);
        #1;
        rst_n = 1'b1;
        saw_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid || psel) saw_rsp++;
        end
        chk("rst_no_rsp", saw_rsp, 0);
        chk("rst_no_write", mem[8'h33], 8'h00);
        wait_n = 0;
        xfer("post_rst_wr", 1'b1, 8'h33, 8'h5A, 3, 8'h00, 1'b0);
        xfer("post_rst_rd", 1'b0, 8'h33, 8'h00, 3, 8'h5A, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
